// File: rtl/internal_node_sender_pkg.sv
// Shared constants and FSM encoding for the internal-node sender and the tree it feeds.
package internal_node_sender_pkg;

  localparam int NODE_WIDTH = 22;   // one internal-node word
  localparam int NODE_COUNT = 127;  // words per tree load (2^7-1)
  localparam int CNT_W      = 7;    // width of the sent/accepted counters

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } node_state_e;

endpackage

// File: rtl/internal_node_sender_if.sv
// Upstream handshake, tree-side output and load status of the internal-node sender.
interface internal_node_sender_if
  import internal_node_sender_pkg::*;
#(
  parameter int W = NODE_WIDTH
);

  logic             start;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             fsm_enable;
  logic             sender_enable;
  logic [W-1:0]     sender_data;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_count;

  modport master (
    output start, in_valid, in_data, fsm_enable,
    input  in_ready, sender_enable, sender_data, busy, done, sent_count
  );

  modport slave (
    input  start, in_valid, in_data, fsm_enable,
    output in_ready, sender_enable, sender_data, busy, done, sent_count
  );

endinterface

// File: rtl/internal_node_sender_sync_fifo.sv
// Synchronous staging FIFO with registered pointers, extra-bit full/empty and a
// combinational head read.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/internal_node_sender.sv
// Streams one tree load of NUM_NODES internal-node words from an upstream
// valid/ready source to the tree, gated by the top-level FSM enable.
module internal_node_sender
  import internal_node_sender_pkg::*;
#(
  parameter int INTERNAL_WIDTH = NODE_WIDTH,
  parameter int NUM_NODES      = NODE_COUNT,
  parameter int FIFO_DEPTH     = 4
) (
  input logic                   clk,
  input logic                   rst_n,   // active-high synchronous reset
  internal_node_sender_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_NODE = CNT_W'(NUM_NODES - 1);
  localparam logic [CNT_W-1:0] ALL_NODES = CNT_W'(NUM_NODES);

  node_state_e               state_q, state_d;
  logic [CNT_W-1:0]          acc_cnt;
  logic [CNT_W-1:0]          sent_cnt;
  logic                      in_load;
  logic                      start_load;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [INTERNAL_WIDTH-1:0] head;

  assign in_load    = (state_q == ST_LOAD);
  assign start_load = (state_q == ST_IDLE) && bus.start;
  assign push       = bus.in_valid && bus.in_ready;
  assign pop        = bus.sender_enable;

  // No full bypass: a pop in the same cycle does not open the input.
  assign bus.in_ready      = in_load && !fifo_full && (acc_cnt < ALL_NODES);
  assign bus.sender_enable = in_load && bus.fsm_enable && !fifo_empty;
  assign bus.sender_data   = bus.sender_enable ? head : '0;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.done          = (state_q == ST_DONE);
  assign bus.sent_count    = sent_cnt;

  sync_fifo #(
    .WIDTH (INTERNAL_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_load),
    .push      (push),
    .push_data (bus.in_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_LOAD;
      ST_LOAD: if (pop && (sent_cnt == LAST_NODE)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      acc_cnt  <= '0;
      sent_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (start_load) begin
        acc_cnt  <= '0;
        sent_cnt <= '0;
      end else if (in_load) begin
        if (push) acc_cnt  <= acc_cnt + 1'b1;
        if (pop)  sent_cnt <= sent_cnt + 1'b1;
      end
    end
  end

endmodule
